// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - round-robin two-port access controller for the 8x8 memory array
module mem_access_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              a_req,
  input  logic              a_op,
  input  logic [ADDR_W-1:0] a_adr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_op,
  input  logic [ADDR_W-1:0] b_adr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_op,
  output logic              mem_select,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RESP} state_t;

  state_t state;
  logic   last_b;
  logic   winner_b;
  logic   grant_b;

  // B wins when it is alone, or on a tie when A was the last one served
  assign grant_b = b_req & (~a_req | ~last_b);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      last_b     <= 1'b1;
      winner_b   <= 1'b0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      busy       <= 1'b0;
      mem_select <= 1'b0;
      rdata      <= '0;
      mem_adr    <= '0;
      mem_wdata  <= '0;
      mem_op     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req | b_req) begin
            winner_b  <= grant_b;
            mem_op    <= grant_b ? b_op    : a_op;
            mem_adr   <= grant_b ? b_adr   : a_adr;
            mem_wdata <= grant_b ? b_wdata : a_wdata;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          mem_select <= 1'b1;
          state      <= STROBE;
        end
        STROBE: begin
          mem_select <= 1'b0;
          if (!mem_op)
            rdata <= mem_rdata;
          a_ack <= ~winner_b;
          b_ack <= winner_b;
          state <= RESP;
        end
        RESP: begin
          a_ack  <= 1'b0;
          b_ack  <= 1'b0;
          last_b <= winner_b;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - directed self-checking bench for mem_access_arbiter
module tb_mem_access_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0, a_op = 1'b0, b_req = 1'b0, b_op = 1'b0;
  logic [2:0] a_adr = '0, b_adr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic       a_ack, b_ack, busy, mem_op, mem_select;
  logic [7:0] rdata, mem_wdata, mem_rdata;
  logic [2:0] mem_adr;
  logic [7:0] mem_model [8];

  int checks = 0;
  int errors = 0;

  mem_access_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .a_req(a_req), .a_op(a_op), .a_adr(a_adr), .a_wdata(a_wdata), .a_ack(a_ack),
    .b_req(b_req), .b_op(b_op), .b_adr(b_adr), .b_wdata(b_wdata), .b_ack(b_ack),
    .rdata(rdata), .busy(busy),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_op(mem_op),
    .mem_select(mem_select), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_model[mem_adr];

  always @(posedge clk) begin
    if (mem_select && mem_op)
      mem_model[mem_adr] <= mem_wdata;
  end

  initial begin
    for (int i = 0; i < 8; i++) mem_model[i] = 8'(8'h11 * i);
  end

  task automatic run_a(input logic op, input logic [2:0] adr, input logic [7:0] wd);
    @(negedge clk);
    a_op = op; a_adr = adr; a_wdata = wd; a_req = 1'b1;
    repeat (3) @(negedge clk);
    a_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL reset_a_ack got %b exp 0", a_ack); end
    checks++; if (b_ack !== 1'b0) begin errors++; $display("FAIL reset_b_ack got %b exp 0", b_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (mem_select !== 1'b0) begin errors++; $display("FAIL reset_select got %b exp 0", mem_select); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", rdata); end
    checks++; if ({mem_adr, mem_wdata, mem_op} !== 12'h000) begin errors++; $display("FAIL reset_mem_bus got %h exp 000", {mem_adr, mem_wdata, mem_op}); end
    rst = 1'b0;
  endtask

  task automatic test_a_write();
    @(negedge clk);
    a_op = 1'b1; a_adr = 3'd3; a_wdata = 8'hA5; a_req = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL aw_c1_busy got %b exp 1", busy); end
    checks++; if (mem_select !== 1'b0) begin errors++; $display("FAIL aw_c1_select got %b exp 0", mem_select); end
    @(negedge clk);
    checks++; if (mem_select !== 1'b1) begin errors++; $display("FAIL aw_c2_select got %b exp 1", mem_select); end
    checks++; if (mem_adr !== 3'd3) begin errors++; $display("FAIL aw_c2_adr got %0d exp 3", mem_adr); end
    checks++; if (mem_wdata !== 8'hA5) begin errors++; $display("FAIL aw_c2_wdata got %h exp a5", mem_wdata); end
    checks++; if (mem_op !== 1'b1) begin errors++; $display("FAIL aw_c2_op got %b exp 1", mem_op); end
    checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL aw_c2_ack got %b exp 0", a_ack); end
    @(negedge clk);
    checks++; if (a_ack !== 1'b1) begin errors++; $display("FAIL aw_c3_a_ack got %b exp 1", a_ack); end
    checks++; if (b_ack !== 1'b0) begin errors++; $display("FAIL aw_c3_b_ack got %b exp 0", b_ack); end
    checks++; if (mem_select !== 1'b0) begin errors++; $display("FAIL aw_c3_select got %b exp 0", mem_select); end
    a_req = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || a_ack !== 1'b0) begin errors++; $display("FAIL aw_c4_idle got busy=%b ack=%b exp 0 0", busy, a_ack); end
    checks++; if (mem_model[3] !== 8'hA5) begin errors++; $display("FAIL aw_mem3 got %h exp a5", mem_model[3]); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL aw_rdata got %h exp 00", rdata); end
  endtask

  task automatic test_b_read();
    @(negedge clk);
    b_op = 1'b0; b_adr = 3'd3; b_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (mem_select !== 1'b1 || mem_op !== 1'b0 || mem_adr !== 3'd3) begin errors++; $display("FAIL br_c2 got sel=%b op=%b adr=%0d exp 1 0 3", mem_select, mem_op, mem_adr); end
    @(negedge clk);
    checks++; if (b_ack !== 1'b1 || a_ack !== 1'b0) begin errors++; $display("FAIL br_c3_acks got a=%b b=%b exp 0 1", a_ack, b_ack); end
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL br_c3_rdata got %h exp a5", rdata); end
    b_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rdata !== 8'hA5 || b_ack !== 1'b0) begin errors++; $display("FAIL br_hold got rdata=%h ack=%b exp a5 0", rdata, b_ack); end
  endtask

  task automatic test_tie_alternate();
    logic ea, eb;
    logic [7:0] er;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_op = 1'b0; a_adr = 3'd1; b_op = 1'b0; b_adr = 3'd2;
    a_req = 1'b1; b_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      ea = (k == 3 || k == 11);
      eb = (k == 7 || k == 15);
      checks++; if (a_ack !== ea || b_ack !== eb) begin errors++; $display("FAIL tie_c%0d got a=%b b=%b exp %b %b", k, a_ack, b_ack, ea, eb); end
      if (ea || eb) begin
        er = ea ? 8'h11 : 8'h22;
        checks++; if (rdata !== er) begin errors++; $display("FAIL tie_rdata_c%0d got %h exp %h", k, rdata, er); end
      end
      if (k == 15) begin a_req = 1'b0; b_req = 1'b0; end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tie_end_busy got %b exp 0", busy); end
  endtask

  task automatic test_addr_change();
    @(negedge clk);
    b_op = 1'b1; b_adr = 3'd5; b_wdata = 8'h3C; b_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (mem_select !== 1'b1 || mem_adr !== 3'd5) begin errors++; $display("FAIL ac_c2 got sel=%b adr=%0d exp 1 5", mem_select, mem_adr); end
    b_adr = 3'd6; b_wdata = 8'hFF; b_op = 1'b0;
    @(negedge clk);
    checks++; if (mem_adr !== 3'd5 || mem_op !== 1'b1 || mem_wdata !== 8'h3C) begin errors++; $display("FAIL ac_c3_bus got adr=%0d op=%b wd=%h exp 5 1 3c", mem_adr, mem_op, mem_wdata); end
    checks++; if (b_ack !== 1'b1 || rdata !== 8'h22) begin errors++; $display("FAIL ac_c3 got ack=%b rdata=%h exp 1 22", b_ack, rdata); end
    b_req = 1'b0;
    @(negedge clk);
    checks++; if (mem_model[5] !== 8'h3C || mem_model[6] !== 8'h66) begin errors++; $display("FAIL ac_mem got m5=%h m6=%h exp 3c 66", mem_model[5], mem_model[6]); end
    checks++; if (rdata !== 8'h22 || mem_adr !== 3'd5) begin errors++; $display("FAIL ac_idle got rdata=%h adr=%0d exp 22 5", rdata, mem_adr); end
  endtask

  task automatic test_reset_mid();
    run_a(1'b1, 3'd0, 8'h77);
    @(negedge clk);
    b_op = 1'b0; b_adr = 3'd4; b_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (mem_select !== 1'b1) begin errors++; $display("FAIL rm_pre_select got %b exp 1", mem_select); end
    rst = 1'b1;
    #1;
    checks++; if (mem_select !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_async got sel=%b busy=%b exp 0 0", mem_select, busy); end
    checks++; if (a_ack !== 1'b0 || b_ack !== 1'b0 || rdata !== 8'h00) begin errors++; $display("FAIL rm_async_ack got a=%b b=%b rdata=%h exp 0 0 00", a_ack, b_ack, rdata); end
    b_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (b_ack !== 1'b0 || a_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_idle_%0d got a=%b b=%b busy=%b exp 0 0 0", k, a_ack, b_ack, busy); end
    end
    a_op = 1'b0; a_adr = 3'd1; b_op = 1'b0; b_adr = 3'd2;
    a_req = 1'b1; b_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin errors++; $display("FAIL rm_tie got a=%b b=%b exp 1 0", a_ack, b_ack); end
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_a_write();
    test_b_read();
    test_tie_alternate();
    test_addr_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
